correlation_arbiter: RTL and testbench

CORRELATION_ARBITER -- requirements
Module: correlation_arbiter

---
 rtl/correlation_arbiter_pkg.sv | 15 +
 rtl/correlation_arbiter_rr_select.sv | 27 ++
 rtl/correlation_arbiter.sv | 126 ++++++++++++
 tb/tb_correlation_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/correlation_arbiter_pkg.sv
// rtl/correlation_arbiter_pkg.sv - shared types and constants for the correlation arbiter
package correlation_arbiter_pkg;

    localparam int CORR_W         = 10;
    localparam int DEF_FILT_SHIFT = 5;
    localparam int DEF_TIMEOUT    = 1024;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/correlation_arbiter_rr_select.sv
// rtl/correlation_arbiter_rr_select.sv - combinational round-robin channel picker
module rr_select #(
    parameter int N_CH = 4,
    parameter int CW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CW-1:0]   rr_ptr,
    output logic [CW-1:0]   idx,
    output logic            found
);

    // First requester strictly after rr_ptr, wrapping; rr_ptr itself is checked last.
    always_comb begin
        int c;
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int k = 1; k <= N_CH; k++) begin
            c = (int'(rr_ptr) + k) % N_CH;
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = CW'(c);
            end
        end
    end

endmodule

// File: rtl/correlation_arbiter.sv
// rtl/correlation_arbiter.sv - round-robin arbiter feeding a shared correlation engine with per-channel IIR filtering
module correlation_arbiter
    import correlation_arbiter_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int FILT_SHIFT = DEF_FILT_SHIFT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          req,
    output logic [N_CH-1:0]          grant,
    output logic                     eng_start,
    output logic [$clog2(N_CH)-1:0]  eng_chan,
    input  logic                     eng_done,
    input  logic [CORR_W-1:0]        eng_corr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(N_CH)-1:0]  out_chan,
    output logic [CORR_W-1:0]        out_corr,
    output logic                     timeout_err
);

    localparam int CW = $clog2(N_CH);
    localparam int TW = $clog2(TIMEOUT);

    state_t              state;
    state_t              next_state;
    logic [CW-1:0]       chan;
    logic [CW-1:0]       rr_ptr;
    logic [CW-1:0]       sel_idx;
    logic                sel_found;
    logic [TW-1:0]       timer;
    logic                timer_last;
    logic [CORR_W-1:0]   filt [N_CH];
    logic [CORR_W:0]     filt_sum;
    logic [CORR_W-1:0]   filt_new;

    rr_select #(.N_CH(N_CH), .CW(CW)) u_rr_select (
        .req    (req),
        .rr_ptr (rr_ptr),
        .idx    (sel_idx),
        .found  (sel_found)
    );

    assign eng_chan   = chan;
    assign timer_last = (timer == TW'(TIMEOUT - 1));

    // IIR update with one spare bit so an overshoot saturates instead of wrapping.
    always_comb begin
        filt_sum = {1'b0, filt[chan]} + {1'b0, eng_corr >> FILT_SHIFT}
                 - {1'b0, filt[chan] >> FILT_SHIFT};
        filt_new = filt_sum[CORR_W] ? {CORR_W{1'b1}} : filt_sum[CORR_W-1:0];
    end

    // Next-state and strobe outputs; eng_done wins over a coincident timeout.
    always_comb begin
        next_state  = state;
        grant       = '0;
        eng_start   = 1'b0;
        out_valid   = 1'b0;
        timeout_err = 1'b0;
        case (state)
            S_IDLE: begin
                if (sel_found) next_state = S_START;
            end
            S_START: begin
                grant[chan] = 1'b1;
                eng_start   = 1'b1;
                next_state  = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    next_state = S_HOLD;
                end else if (timer_last) begin
                    timeout_err = 1'b1;
                    next_state  = S_IDLE;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State, job registers, filter array and result holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rr_ptr   <= CW'(N_CH - 1);
            chan     <= '0;
            timer    <= '0;
            out_corr <= '0;
            out_chan <= '0;
            for (int i = 0; i < N_CH; i++) filt[i] <= '0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    if (sel_found) chan <= sel_idx;
                end
                S_START: begin
                    timer <= '0;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        filt[chan] <= filt_new;
                        out_corr   <= filt_new;
                        out_chan   <= chan;
                    end else if (timer_last) begin
                        rr_ptr <= chan;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) rr_ptr <= chan;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_correlation_arbiter.sv
// tb/tb_correlation_arbiter.sv - directed self-checking bench for correlation_arbiter
module tb_correlation_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       eng_start;
    logic [1:0] eng_chan;
    logic       eng_done;
    logic [9:0] eng_corr;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_chan;
    logic [9:0] out_corr;
    logic       timeout_err;

    int compared = 0;
    int failed   = 0;

    correlation_arbiter #(.N_CH(4), .TIMEOUT(16), .FILT_SHIFT(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .eng_start   (eng_start),
        .eng_chan    (eng_chan),
        .eng_done    (eng_done),
        .eng_corr    (eng_corr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_chan    (out_chan),
        .out_corr    (out_corr),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        int         lat;
        logic [9:0] corr;
        int         dly;
        logic [1:0] ch;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_grant(output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (grant == 4'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = (grant != 4'b0);
        if (!ok) begin
            compared++;
            failed++;
            $display("FAIL grant_wait: got no grant expected a grant within 20 cycles");
        end
    endtask

    task automatic run_job(input logic [3:0] r, input int lat, input logic [9:0] corr,
                           input int dly, input logic [1:0] ec, input logic [9:0] ecorr);
        bit         ok;
        logic [9:0] held;
        req = r;
        wait_grant(ok);
        if (!ok) begin
            req = 4'b0;
            return;
        end
        chk("grant", grant, 32'(4'b0001 << ec));
        chk("eng_start", eng_start, 1);
        chk("eng_chan", eng_chan, ec);
        req = ~r;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            if (i == lat) begin
                eng_done  = 1'b1;
                eng_corr  = corr;
                out_ready = (dly == 0);
            end
            #1;
            chk("wait_eng_start", eng_start, 0);
            chk("wait_grant", grant, 0);
            chk("wait_timeout_err", timeout_err, 0);
            chk("wait_eng_chan", eng_chan, ec);
        end
        @(negedge clk);
        eng_done = 1'b0;
        eng_corr = 10'd0;
        req      = r;
        chk("out_valid", out_valid, 1);
        chk("out_chan", out_chan, ec);
        chk("out_corr", out_corr, ecorr);
        held = out_corr;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_corr", out_corr, held);
            chk("hold_no_start", eng_start, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("out_valid_drop", out_valid, 0);
    endtask

    initial begin
        bit         ok;
        logic [9:0] f;
        logic [9:0] prev;
        int         fn;

        tbl[0] = '{4'b0001, 3, 10'd640,  0,  2'd0, 10'd20};
        tbl[1] = '{4'b1111, 2, 10'd320,  0,  2'd1, 10'd10};
        tbl[2] = '{4'b1111, 2, 10'd1023, 0,  2'd2, 10'd31};
        tbl[3] = '{4'b1111, 2, 10'd64,   0,  2'd3, 10'd2};
        tbl[4] = '{4'b1111, 2, 10'd640,  0,  2'd0, 10'd40};
        tbl[5] = '{4'b1010, 1, 10'd1000, 10, 2'd1, 10'd41};
        tbl[6] = '{4'b1010, 4, 10'd0,    2,  2'd3, 10'd2};
        tbl[7] = '{4'b0100, 1, 10'd512,  0,  2'd2, 10'd47};
        tbl[8] = '{4'b0001, 1, 10'd1023, 0,  2'd0, 10'd70};
        tbl[9] = '{4'b1001, 1, 10'd0,    0,  2'd3, 10'd2};

        rst       = 1'b1;
        req       = 4'b0;
        eng_done  = 1'b0;
        eng_corr  = 10'd0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_out_corr", out_corr, 0);
        chk("rst_out_chan", out_chan, 0);
        chk("rst_eng_chan", eng_chan, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 10; v++)
            run_job(tbl[v].req, tbl[v].lat, tbl[v].corr, tbl[v].dly, tbl[v].ch, tbl[v].exp);

        // Engine never answers: abort on the 16th WAIT cycle, then move on.
        req = 4'b0011;
        wait_grant(ok);
        if (ok) begin
            chk("to_grant", grant, 4'b0001);
            for (int i = 1; i <= 16; i++) begin
                @(negedge clk);
                #1;
                chk("to_pulse", timeout_err, (i == 16) ? 1 : 0);
                chk("to_no_valid", out_valid, 0);
            end
            @(negedge clk);
            chk("to_pulse_end", timeout_err, 0);
        end
        run_job(4'b0011, 1, 10'd0, 0, 2'd1, 10'd40);
        run_job(4'b0001, 1, 10'd0, 0, 2'd0, 10'd68);
        run_job(4'b0100, 16, 10'd1023, 0, 2'd2, 10'd77);

        // Reset in WAIT, then a stray eng_done from the abandoned job.
        req = 4'b0010;
        wait_grant(ok);
        req = 4'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_eng_start", eng_start, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_corr", out_corr, 0);
        chk("mid_rst_out_chan", out_chan, 0);
        chk("mid_rst_eng_chan", eng_chan, 0);
        chk("mid_rst_timeout", timeout_err, 0);
        eng_done = 1'b1;
        eng_corr = 10'd1023;
        @(negedge clk);
        eng_done = 1'b0;
        eng_corr = 10'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_out_valid", out_valid, 0);
            chk("stray_grant", grant, 0);
            chk("stray_timeout", timeout_err, 0);
        end
        run_job(4'b0101, 2, 10'd640, 0, 2'd0, 10'd20);

        // Repeated full-scale input on channel 1 climbs to its fixed point.
        f    = 10'd0;
        prev = 10'd0;
        for (int k = 0; k < 200; k++) begin
            fn = int'(f) + 31 - int'(f >> 5);
            if (fn > 1023) fn = 1023;
            f = 10'(fn);
            run_job(4'b0010, 1, 10'd1023, 0, 2'd1, f);
            chk("conv_monotonic", (out_corr >= prev), 1);
            prev = out_corr;
        end
        chk("conv_final", out_corr, 10'd992);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
